imem_server: RTL and testbench
==============================

Name: imem_server

Overview:
Instruction-memory responder on the far end of the core's fetch handshake. The fetch stage presents a word-indexed pc plus a valid strobe and waits for a completion strobe with the raw instruction. Before serving fetches, the block loads the program from a byte stream supplied by the UART receiver: a 4-byte little-endian word count, then that many little-endian instruction words. It then serves one outstanding fetch at a time, with a fixed latency and flush support for mispredict recovery.

Parameters:
ADDR_W, 10, word-address width; memory holds 2^ADDR_W 32-bit words.
LATENCY, 1, cycles from request acceptance to response; legal range 1..4.

Ports:
clk  in  1  clock, all state updates on posedge.
rstn  in  1  asynchronous active-low reset.
load_valid  in  1  one program byte present this cycle.
load_byte  in  8  program byte.
loaded  out  1  level; high once the full program is written.
load_err  out  1  sticky; the declared length exceeded capacity.
req_valid  in  1  fetch request (fetch enabled).
req_addr  in  32  word address (pc; pc+1 is the next word).
req_ready  out  1  request accepted at this edge if req_valid.
flush  in  1  cancels any in-flight request (fetch reset on mispredict).
resp_valid  out  1  one-cycle completion pulse.
resp_instr  out  32  instruction; valid while resp_valid is high.

Behaviour:
- States: LOAD_LEN, LOAD_DATA, IDLE, BUSY.
- Reset values: state=LOAD_LEN, byte_cnt=0, word_cnt=0, len=0, loaded=0, load_err=0, resp_valid=0, resp_instr=0, busy counter=0. Memory contents are not cleared.
- req_ready = (state==IDLE) && !flush. This is combinational from registered state.

LOAD_LEN:
- Each load_valid shifts a byte into len, little-endian (first byte = len[7:0]).
- On the 4th byte, the next state is decided:
  - len==0 -> IDLE, loaded=1.
  - len>2^ADDR_W -> load_err=1, len clamped to 2^ADDR_W, go to LOAD_DATA.
  - otherwise -> LOAD_DATA.

LOAD_DATA:
- Bytes assemble little-endian into a word.
- On the 4th byte, write mem[word_cnt] and increment word_cnt.
- When word_cnt reaches len-1 and that word is written -> IDLE, loaded=1 at the same edge.
- Bytes beyond the clamped length are ignored.

Request handling:
- In LOAD_* states, req_valid is ignored and no response is produced.
- After loaded=1, load_valid is ignored.
- IDLE: if req_valid && req_ready at edge k, capture req_addr and go to BUSY.
- Response timing: resp_valid=1 during the cycle after edge k+LATENCY-1 (i.e. registered at edge k+LATENCY-1 for LATENCY=1, and in general LATENCY cycles after acceptance). It is high for exactly one cycle.
- resp_instr = mem[req_addr[ADDR_W-1:0]] if req_addr[31:ADDR_W]==0; otherwise NOP_INSTR (32'h00000013).
- State returns to IDLE at the same edge that raises resp_valid, so req_ready is high alongside resp_valid. Throughput is one fetch per LATENCY cycles.
- resp_instr holds its last value when resp_valid=0.

flush:
- In BUSY: the request is dropped, no resp_valid is ever produced for it, and the state goes to IDLE at the next edge.
- In IDLE: flush together with req_valid means flush wins (req_ready=0) and nothing is accepted.
- flush at the same edge a response would be raised suppresses that response.
- flush in LOAD_* states has no effect.

Reset mid-operation:
- Reset during load returns to LOAD_LEN; the partial program is discarded (loaded=0).
- Reset during BUSY drops the request; resp_valid=0 immediately (asynchronous).

Decomposition:
- Shared package (alongside the core's definitions): NOP_INSTR constant and the imem_state_t enum {LOAD_LEN, LOAD_DATA, IDLE, BUSY}.
- One sub-module, imem_ram: a single-port synchronous RAM with 2^ADDR_W x 32 words, write enable, and a registered read. Write and read are mutually exclusive by state. The remaining LATENCY-1 cycles are delay stages in imem_server.

Test Plan:
- Load bytes 03 00 00 00, 13 05 10 00, 93 05 20 00, 33 86 B5 00 -> loaded rises on the 16th byte; fetching addresses 0,1,2 with LATENCY=1 returns 0x00100513, 0x00200593, 0x00B58633, each resp_valid exactly 1 cycle after acceptance.
- LATENCY=3, back-to-back req_valid held high -> accepts at cycles 0, 3, 6; resp_valid at 3, 6, 9; req_ready low in between.
- Request for addr 1 accepted, flush asserted 1 cycle later (LATENCY=3) -> no resp_valid; a new request for addr 2 accepted the following cycle returns 0x00B58633.
- ADDR_W=4, length bytes 20 00 00 00 (32 words) -> load_err=1, exactly 16 words written, loaded high after 64 data bytes, later bytes ignored.
- Fetch addr 0x0000_0400 with ADDR_W=10 -> resp_instr=0x00000013.
- rstn pulsed low after 6 of 16 load bytes, then a full reload of a different program -> loaded=0 during reload; fetch of addr 0 returns the new word.
- req_valid during LOAD_DATA -> req_ready=0 and no response is produced.

Source files
------------

// File: rtl/imem_server_pkg.sv
// Shared definitions for the instruction-memory responder: the NOP filler
// returned for out-of-range fetches and the controller state encoding.
package imem_server_pkg;

  // addi x0, x0, 0 -- harmless filler for fetches outside the memory.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    LOAD_LEN,
    LOAD_DATA,
    IDLE,
    BUSY
  } imem_state_t;

endpackage

// File: rtl/imem_server_if.sv
// Fetch handshake between the core's fetch stage (master) and the
// instruction memory (slave): request/ready, flush, and the response pulse.
interface imem_server_if;

  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_instr;

  modport master (
    output req_valid,
    output req_addr,
    output flush,
    input  req_ready,
    input  resp_valid,
    input  resp_instr
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  flush,
    output req_ready,
    output resp_valid,
    output resp_instr
  );

endinterface

// File: rtl/imem_server_ram.sv
// Single-port 2^ADDR_W x 32 program memory with a registered read port.
// The controller never writes and reads in the same cycle.
module imem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_reg [2**ADDR_W];

  // Program write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[addr] <= wdata;
    end
  end

  // Registered read; holds the last word fetched so the response stays stable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= 32'h0;
    end else if (re) begin
      rdata <= mem_reg[addr];
    end
  end

endmodule

// File: rtl/imem_server.sv
// Instruction-memory responder: loads a length-prefixed little-endian
// program from a byte stream, then serves one fetch at a time with a fixed
// latency. The RAM read is issued on the edge that raises resp_valid, so the
// read data and the response strobe appear together; earlier cycles of the
// latency are counted down in BUSY.
module imem_server
  import imem_server_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_valid,
  input  logic [7:0]   load_byte,
  output logic         loaded,
  output logic         load_err,
  imem_server_if.slave fetch
);

  localparam logic [31:0] CAPACITY  = 32'd1 << ADDR_W;
  localparam logic [2:0]  BUSY_INIT = 3'(LATENCY - 1);

  imem_state_t       state_reg, state_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [ADDR_W:0]   word_cnt_reg, word_cnt_next;
  logic [31:0]       len_reg, len_next;
  logic [23:0]       word_reg, word_next;
  logic              loaded_reg, loaded_next;
  logic              load_err_reg, load_err_next;
  logic              resp_valid_reg, resp_valid_next;
  logic [2:0]        busy_cnt_reg, busy_cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              hi_reg, hi_next;
  logic              nop_reg, nop_next;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic [31:0]       len_assembled;
  logic [ADDR_W:0]   len_last;
  logic              req_hi_nz;
  logic              accept;

  assign len_assembled   = {load_byte, len_reg[31:8]};
  assign len_last        = len_reg[ADDR_W:0] - {{ADDR_W{1'b0}}, 1'b1};
  assign req_hi_nz       = |fetch.req_addr[31:ADDR_W];
  assign fetch.req_ready = (state_reg == IDLE) && !fetch.flush;
  assign accept          = fetch.req_ready && fetch.req_valid;

  assign loaded           = loaded_reg;
  assign load_err         = load_err_reg;
  assign fetch.resp_valid = resp_valid_reg;
  assign fetch.resp_instr = nop_reg ? NOP_INSTR : ram_rdata;

  imem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next-state logic for loading, request acceptance and latency countdown.
  always_comb begin
    state_next      = state_reg;
    byte_cnt_next   = byte_cnt_reg;
    word_cnt_next   = word_cnt_reg;
    len_next        = len_reg;
    word_next       = word_reg;
    loaded_next     = loaded_reg;
    load_err_next   = load_err_reg;
    resp_valid_next = 1'b0;
    busy_cnt_next   = busy_cnt_reg;
    addr_next       = addr_reg;
    hi_next         = hi_reg;
    nop_next        = nop_reg;
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    ram_addr        = addr_reg;
    ram_wdata       = {load_byte, word_reg};

    unique case (state_reg)
      LOAD_LEN: begin
        if (load_valid) begin
          len_next      = len_assembled;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            if (len_assembled == 32'd0) begin
              state_next  = IDLE;
              loaded_next = 1'b1;
            end else if (len_assembled > CAPACITY) begin
              load_err_next = 1'b1;
              len_next      = CAPACITY;
              state_next    = LOAD_DATA;
            end else begin
              state_next = LOAD_DATA;
            end
          end
        end
      end

      LOAD_DATA: begin
        ram_addr = word_cnt_reg[ADDR_W-1:0];
        if (load_valid) begin
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            ram_we        = 1'b1;
            word_cnt_next = word_cnt_reg + 1'b1;
            if (word_cnt_reg == len_last) begin
              state_next  = IDLE;
              loaded_next = 1'b1;
            end
          end else begin
            word_next = {load_byte, word_reg[23:8]};
          end
        end
      end

      IDLE: begin
        ram_addr = fetch.req_addr[ADDR_W-1:0];
        if (accept) begin
          if (LATENCY == 1) begin
            ram_re          = 1'b1;
            nop_next        = req_hi_nz;
            resp_valid_next = 1'b1;
          end else begin
            state_next    = BUSY;
            busy_cnt_next = BUSY_INIT;
            addr_next     = fetch.req_addr[ADDR_W-1:0];
            hi_next       = req_hi_nz;
          end
        end
      end

      BUSY: begin
        if (fetch.flush) begin
          state_next    = IDLE;
          busy_cnt_next = 3'd0;
        end else if (busy_cnt_reg == 3'd1) begin
          ram_re          = 1'b1;
          nop_next        = hi_reg;
          resp_valid_next = 1'b1;
          state_next      = IDLE;
          busy_cnt_next   = 3'd0;
        end else begin
          busy_cnt_next = busy_cnt_reg - 3'd1;
        end
      end

      default: state_next = LOAD_LEN;
    endcase
  end

  // State and datapath registers; reset discards any partial load or fetch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= LOAD_LEN;
      byte_cnt_reg   <= 2'd0;
      word_cnt_reg   <= '0;
      len_reg        <= 32'd0;
      word_reg       <= 24'd0;
      loaded_reg     <= 1'b0;
      load_err_reg   <= 1'b0;
      resp_valid_reg <= 1'b0;
      busy_cnt_reg   <= 3'd0;
      addr_reg       <= '0;
      hi_reg         <= 1'b0;
      nop_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      byte_cnt_reg   <= byte_cnt_next;
      word_cnt_reg   <= word_cnt_next;
      len_reg        <= len_next;
      word_reg       <= word_next;
      loaded_reg     <= loaded_next;
      load_err_reg   <= load_err_next;
      resp_valid_reg <= resp_valid_next;
      busy_cnt_reg   <= busy_cnt_next;
      addr_reg       <= addr_next;
      hi_reg         <= hi_next;
      nop_reg        <= nop_next;
    end
  end

endmodule

// File: tb/tb_imem_server.sv
// Randomized bench for imem_server: two instances (ADDR_W=10/LATENCY=1 and
// ADDR_W=4/LATENCY=3) share one stimulus stream and are checked every cycle
// against a transaction-level model of loading and fetch timing.
module tb_imem_server;
  import imem_server_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        flush = 1'b0;
  logic        loaded_a, err_a, loaded_b, err_b;

  always #5 clk = ~clk;

  imem_server_if if_a ();
  imem_server_if if_b ();

  assign if_a.req_valid = req_valid;
  assign if_a.req_addr  = req_addr;
  assign if_a.flush     = flush;
  assign if_b.req_valid = req_valid;
  assign if_b.req_addr  = req_addr;
  assign if_b.flush     = flush;

  imem_server #(.ADDR_W(10), .LATENCY(1)) dut_a (
    .clk        (clk),
    .rstn       (rstn),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .loaded     (loaded_a),
    .load_err   (err_a),
    .fetch      (if_a)
  );

  imem_server #(.ADDR_W(4), .LATENCY(3)) dut_b (
    .clk        (clk),
    .rstn       (rstn),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .loaded     (loaded_b),
    .load_err   (err_b),
    .fetch      (if_b)
  );

  logic        o_rdy [2];
  logic        o_rv  [2];
  logic        o_ld  [2];
  logic        o_le  [2];
  logic [31:0] o_ri  [2];

  assign o_rdy[0] = if_a.req_ready;
  assign o_rdy[1] = if_b.req_ready;
  assign o_rv[0]  = if_a.resp_valid;
  assign o_rv[1]  = if_b.resp_valid;
  assign o_ri[0]  = if_a.resp_instr;
  assign o_ri[1]  = if_b.resp_instr;
  assign o_ld[0]  = loaded_a;
  assign o_ld[1]  = loaded_b;
  assign o_le[0]  = err_a;
  assign o_le[1]  = err_b;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          aw  [2];
  int          lat [2];
  logic [31:0] m_mem [2][1024];
  bit          m_loaded [2];
  bit          m_err [2];
  bit          m_inflight [2];
  int          m_nbytes [2];
  logic [31:0] m_len [2];
  logic [31:0] m_wacc [2];
  logic [31:0] m_pend [2];
  logic [31:0] m_last [2];
  int          m_resp_cyc [2];
  int          m_busy_until [2];
  int          cyc = 0;

  function automatic logic [31:0] fetch_ref(input int d, input logic [31:0] a);
    if ((a >> aw[d]) != 0) return NOP_INSTR;
    return m_mem[d][a[9:0]];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_loaded[d] = 0; m_err[d] = 0; m_inflight[d] = 0;
      m_nbytes[d] = 0; m_len[d] = 0; m_wacc[d] = 0;
      m_last[d] = 0; m_busy_until[d] = 0; m_resp_cyc[d] = 0;
    end
  endtask

  task automatic model_byte(input int d, input logic [7:0] b);
    int k;
    logic [31:0] cap;
    if (m_nbytes[d] < 4) begin
      m_len[d] = m_len[d] | (32'(b) << (8 * m_nbytes[d]));
      m_nbytes[d]++;
      if (m_nbytes[d] == 4) begin
        cap = 32'd1 << aw[d];
        if (m_len[d] == 0) m_loaded[d] = 1;
        else if (m_len[d] > cap) begin
          m_err[d] = 1;
          m_len[d] = cap;
        end
      end
    end else begin
      k = m_nbytes[d] - 4;
      m_nbytes[d]++;
      if (k % 4 == 0) m_wacc[d] = 32'(b);
      else m_wacc[d] = m_wacc[d] | (32'(b) << (8 * (k % 4)));
      if (k % 4 == 3) begin
        m_mem[d][k / 4] = m_wacc[d];
        if (k / 4 == int'(m_len[d]) - 1) m_loaded[d] = 1;
      end
    end
  endtask

  // Advance the model across one clock edge using this cycle's inputs.
  task automatic model_edge(input int d);
    if (!m_loaded[d]) begin
      if (load_valid) model_byte(d, load_byte);
    end else begin
      if (m_inflight[d] && cyc == m_resp_cyc[d]) m_inflight[d] = 0;
      if (m_inflight[d] && flush) begin
        m_inflight[d]   = 0;
        m_busy_until[d] = cyc + 1;
      end
      if (req_valid && !flush && cyc >= m_busy_until[d]) begin
        m_inflight[d]   = 1;
        m_resp_cyc[d]   = cyc + lat[d];
        m_busy_until[d] = cyc + lat[d];
        m_pend[d]       = fetch_ref(d, req_addr);
      end
    end
  endtask

  task automatic step();
    bit exp_rdy, exp_rv;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      exp_rdy = m_loaded[d] && (cyc >= m_busy_until[d]) && !flush;
      exp_rv  = m_inflight[d] && (cyc == m_resp_cyc[d]);
      if (exp_rv) m_last[d] = m_pend[d];
      check($sformatf("req_ready[%0d]@%0d", d, cyc), 32'(o_rdy[d]), 32'(exp_rdy));
      check($sformatf("resp_valid[%0d]@%0d", d, cyc), 32'(o_rv[d]), 32'(exp_rv));
      check($sformatf("resp_instr[%0d]@%0d", d, cyc), o_ri[d], m_last[d]);
      check($sformatf("loaded[%0d]@%0d", d, cyc), 32'(o_ld[d]), 32'(m_loaded[d]));
      check($sformatf("load_err[%0d]@%0d", d, cyc), 32'(o_le[d]), 32'(m_err[d]));
      model_edge(d);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; load_valid = 1'b0; req_valid = 1'b0; flush = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready[%0d]", d), 32'(o_rdy[d]), 32'd0);
      check($sformatf("rst_resp_valid[%0d]", d), 32'(o_rv[d]), 32'd0);
      check($sformatf("rst_resp_instr[%0d]", d), o_ri[d], 32'd0);
      check($sformatf("rst_loaded[%0d]", d), 32'(o_ld[d]), 32'd0);
      check($sformatf("rst_load_err[%0d]", d), 32'(o_le[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] byteq[$];
  int  req_pct   = 0;
  int  flush_pct = 0;
  int  addr_max  = 3;
  bit  hold_req  = 0;

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) byteq.push_back(8'(w >> (8 * i)));
  endtask

  task automatic cycle_stim();
    int r;
    if (byteq.size() > 0 && $urandom_range(3) != 0) begin
      load_valid = 1'b1;
      load_byte  = byteq.pop_front();
    end else begin
      load_valid = 1'b0;
      load_byte  = 8'($urandom);
    end
    req_valid = hold_req ? 1'b1 : ($urandom_range(99) < req_pct);
    flush     = ($urandom_range(99) < flush_pct);
    r = $urandom_range(9);
    if (r == 0) req_addr = 32'h0000_0400;
    else if (r == 1) req_addr = $urandom | 32'h8000_0000;
    else req_addr = $urandom_range(addr_max - 1);
    step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_stim();
  endtask

  task automatic drain_load();
    for (int i = 0; i < 3000 && byteq.size() > 0; i++) cycle_stim();
    check("load_drain_timeout", byteq.size(), 32'd0);
    run(4);
  endtask

  initial begin
    aw[0] = 10; aw[1] = 4; lat[0] = 1; lat[1] = 3;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Three-word program; fetch requests during loading must be ignored.
    push_word(32'd3);
    push_word(32'h0010_0513); push_word(32'h0020_0593); push_word(32'h00B5_8633);
    req_pct = 40; addr_max = 3;
    drain_load();
    req_pct = 60;
    run(60);

    // Back-to-back requests held high: throughput set by latency.
    hold_req = 1;
    run(20);
    hold_req = 0; req_pct = 0;
    run(5);

    // Directed flush one cycle after acceptance, then a fresh request.
    load_valid = 0; req_valid = 1; req_addr = 32'd1; flush = 0; step();
    req_valid = 0; flush = 1; step();
    flush = 0; req_valid = 1; req_addr = 32'd2; step();
    req_valid = 0;
    for (int i = 0; i < 6; i++) step();

    // Random fetches with flushes.
    req_pct = 60; flush_pct = 15;
    run(200);

    // Reset while a fetch is in flight, then an oversized program.
    flush_pct = 0;
    load_valid = 0; req_valid = 1; req_addr = 32'd0; flush = 0; step();
    do_reset();
    push_word(32'd32);
    for (int i = 0; i < 32; i++) push_word($urandom);
    push_word($urandom); push_word($urandom);
    req_pct = 40; flush_pct = 10; addr_max = 32;
    drain_load();
    run(200);

    // Reset after 6 of 16 bytes, then reload a different program.
    byteq.delete();
    req_pct = 30; flush_pct = 0; addr_max = 3;
    do_reset();
    push_word(32'd3);
    push_word(32'h1111_1111); push_word(32'h2222_2222); push_word(32'h3333_3333);
    for (int i = 0; i < 200 && byteq.size() > 10; i++) cycle_stim();
    do_reset();
    byteq.delete();
    push_word(32'd3);
    push_word(32'hCAFE_0093); push_word(32'h0041_8213); push_word(32'hDEAD_BEEF);
    drain_load();
    req_pct = 70; flush_pct = 10;
    run(100);

    // Zero-length program: serve immediately from retained memory.
    do_reset();
    push_word(32'd0);
    push_word(32'h5555_5555);
    drain_load();
    run(60);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
